// File: rtl/mux_dff_bist_pkg.sv
// Shared types and constants for the mux flop built-in self-test engine.
//   state_t    : run-sequencer states
//   LFSR_W     : stimulus LFSR width
//   LFSR_TAPS  : tap mask for x^8+x^6+x^5+x^4+1 (Fibonacci, shift left)
//   CNT_W      : width of the vector index, timer and result counters
//   ERR_MAX    : saturation value of the error counter
//   NO_FAIL    : fail_vec value meaning "no mismatch seen"
//   lfsr_next(): one LFSR step
package mux_dff_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_VEC = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam int               LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS   = 8'hB8;
    localparam int               CNT_W        = 16;
    localparam logic [CNT_W-1:0] ERR_MAX      = 16'hFFFF;
    localparam logic [CNT_W-1:0] NO_FAIL      = 16'hFFFF;
    // Two cycles let the last vector pass through the flop and the compare pipe.
    localparam int               DRAIN_CYCLES = 2;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mux_dff_bist_lfsr.sv
// Stimulus LFSR for the mux flop self-test.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, loads the seed
//   load   : reload the seed (takes priority over enable)
//   enable : advance one step
//   seed   : seed value; an all-zero seed is replaced by 1 so the LFSR never locks up
//   state  : current LFSR value
module mux_dff_bist_lfsr
    import mux_dff_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enable,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] seed_safe;

    assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed_safe;
        end else if (load) begin
            state <= seed_safe;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/mux_dff_bist.sv
// Built-in self-test engine for the registered 2:1 mux flop.
// Drives the flop from an LFSR, predicts q, compares two cycles later and
// reports pass/fail, a saturating error count and the first failing index.
//
// Optional build macro: MUX_DFF_BIST_STOP_ON_FAIL_EN
//   defined   -> first mismatch ends the run on the next edge
//   undefined -> every vector runs regardless of mismatches
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, accepted only in IDLE
//   busy                : run in progress
//   done                : one-cycle pulse at run end
//   pass                : last run result, valid from done until next start
//   err_count           : mismatches in last run, saturating
//   fail_vec            : first mismatching vector index, FFFF if none
//   dut_d0/d1/sel/rst   : registered stimulus to the mux flop
//   dut_q               : mux flop output
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | flop held in reset, waiting for start
// RST_VEC | drive vector 0 (flop reset with d0=d1=1), expect q=0
// RUN     | drive vectors 1..NUM_VECTORS from the LFSR
// DRAIN   | flop held in reset while the last compares complete
// FIN     | publish pass, pulse done, return to IDLE
module mux_dff_bist
    import mux_dff_bist_pkg::*;
#(
    parameter int unsigned       NUM_VECTORS = 256,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] fail_vec,
    output logic             dut_d0,
    output logic             dut_d1,
    output logic             dut_sel,
    output logic             dut_rst,
    input  logic             dut_q
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  vec_idx_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_load, lfsr_en;
    logic              unused_lfsr_hi;

    logic drv_rst, drv_d0, drv_d1, drv_sel, drv_valid, drv_exp;

    // Expected-value pipeline: stage 1 follows the vector onto the pins,
    // stage 2 lines up with the cycle the flop has captured it.
    logic             v1_q, e1_q, v2_q, e2_q;
    logic [CNT_W-1:0] i1_q, i2_q;

    logic mismatch, stop_hit;

    mux_dff_bist_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (LFSR_SEED),
        .state  (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:3];

    assign mismatch = v2_q & (dut_q ^ e2_q);

`ifdef MUX_DFF_BIST_STOP_ON_FAIL_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        drv_rst   = 1'b1;
        drv_d0    = 1'b0;
        drv_d1    = 1'b0;
        drv_sel   = 1'b0;
        drv_valid = 1'b0;
        drv_exp   = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RST_VEC;
                    lfsr_load = 1'b1;
                end
            end
            RST_VEC: begin
                drv_d0    = 1'b1;
                drv_d1    = 1'b1;
                drv_sel   = lfsr_q[2];
                drv_valid = 1'b1;
                timer_d   = CNT_W'(NUM_VECTORS - 1);
                state_d   = RUN;
            end
            RUN: begin
                drv_rst   = 1'b0;
                drv_d0    = lfsr_q[0];
                drv_d1    = lfsr_q[1];
                drv_sel   = lfsr_q[2];
                drv_valid = 1'b1;
                drv_exp   = lfsr_q[2] ? lfsr_q[1] : lfsr_q[0];
                lfsr_en   = 1'b1;
                if (timer_q == '0) begin
                    state_d = DRAIN;
                    timer_d = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DRAIN: begin
                if (timer_q == '0) begin
                    state_d = FIN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop_hit) begin
            state_d = FIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            vec_idx_q <= '0;
            dut_rst   <= 1'b1;
            dut_d0    <= 1'b0;
            dut_d1    <= 1'b0;
            dut_sel   <= 1'b0;
            v1_q      <= 1'b0;
            e1_q      <= 1'b0;
            i1_q      <= '0;
            v2_q      <= 1'b0;
            e2_q      <= 1'b0;
            i2_q      <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dut_rst <= drv_rst;
            dut_d0  <= drv_d0;
            dut_d1  <= drv_d1;
            dut_sel <= drv_sel;

            if (state_q == IDLE && start) begin
                vec_idx_q <= '0;
            end else if (drv_valid) begin
                vec_idx_q <= vec_idx_q + 1'b1;
            end

            v1_q <= drv_valid;
            e1_q <= drv_exp;
            i1_q <= vec_idx_q;
            v2_q <= v1_q;
            e2_q <= e1_q;
            i2_q <= i1_q;
            // Early stop: anything still in flight belongs to an abandoned run.
            if (stop_hit) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= NO_FAIL;
        end else begin
            done <= (state_q == FIN);
            if (state_q == IDLE && start) begin
                busy      <= 1'b1;
                err_count <= '0;
                fail_vec  <= NO_FAIL;
            end else if (state_q == FIN) begin
                busy <= 1'b0;
                pass <= (err_count == '0);
            end else if (mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 1'b1;
                end
                if (fail_vec == NO_FAIL) begin
                    fail_vec <= i2_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_dff_bist.sv
// Self-checking bench for mux_dff_bist with a behavioural mux flop that can
// be forced stuck-at-0 or stuck-at-1. Per-vector stimulus is checked against
// a hand-computed table for seed A5, NUM_VECTORS=16.
module tb_mux_dff_bist;

    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count, fail_vec;
    logic        dut_d0, dut_d1, dut_sel, dut_rst;
    logic        dut_q;
    logic        q_model = 1'b0;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int fault = 0;

    typedef struct {
        logic rst;
        logic d0;
        logic d1;
        logic sel;
        logic q;
    } vec_t;

    vec_t tbl [0:NV];

    always #5 clk = ~clk;

    mux_dff_bist #(.NUM_VECTORS(NV), .LFSR_SEED(8'hA5)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec),
        .dut_d0    (dut_d0),
        .dut_d1    (dut_d1),
        .dut_sel   (dut_sel),
        .dut_rst   (dut_rst),
        .dut_q     (dut_q)
    );

    always @(posedge clk) q_model <= dut_rst ? 1'b0 : (dut_sel ? dut_d1 : dut_d0);
    assign dut_q = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : q_model;

    always @(negedge clk) if (done) done_cnt++;

    function automatic vec_t mk(input logic r, input logic a, input logic b,
                                input logic s, input logic q);
        vec_t v;
        v.rst = r; v.d0 = a; v.d1 = b; v.sel = s; v.q = q;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stim(input int k);
        check($sformatf("stim_v%0d", k), {28'd0, dut_rst, dut_d0, dut_d1, dut_sel},
              {28'd0, tbl[k].rst, tbl[k].d0, tbl[k].d1, tbl[k].sel});
    endtask

    // Negedge i follows edge E+i-1, where E is the start edge.
    // Vector k is visible at negedge k+2; done at negedge exp_lat.
    task automatic run(input string tag, input int f, input int exp_lat,
                       input logic exp_pass, input logic [15:0] exp_err,
                       input logic [15:0] exp_fv, input int spur1, input int spur2);
        int lat;
        int dc0;
        fault = f;
        dc0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        lat = 0;
        for (int i = 2; i <= 60; i++) begin
            @(negedge clk);
            start = (i == spur1) || (i == spur2);
            if (done) begin
                lat = i;
                break;
            end
            if (i - 2 <= NV) check_stim(i - 2);
        end
        start = 1'b0;
        check({tag, "_done_latency"}, lat, exp_lat);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_err_count"}, err_count, exp_err);
        check({tag, "_fail_vec"}, fail_vec, exp_fv);
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse_low"}, done, 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_cnt - dc0, 1);
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 1, 1, 0);
        tbl[1]  = mk(0, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0, 0, 1);
        tbl[7]  = mk(0, 1, 1, 0, 1);
        tbl[8]  = mk(0, 1, 1, 1, 1);
        tbl[9]  = mk(0, 0, 1, 1, 1);
        tbl[10] = mk(0, 1, 0, 1, 0);
        tbl[11] = mk(0, 1, 1, 0, 1);
        tbl[12] = mk(0, 1, 1, 1, 1);
        tbl[13] = mk(0, 0, 1, 1, 1);
        tbl[14] = mk(0, 1, 0, 1, 0);
        tbl[15] = mk(0, 1, 1, 0, 1);
        tbl[16] = mk(0, 0, 1, 1, 1);

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_fail_vec", fail_vec, 16'hFFFF);
        check("rst_stim", {dut_rst, dut_d0, dut_d1, dut_sel}, 4'b1000);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Model self-consistency: table q column follows the mux equation.
        for (int k = 1; k <= NV; k++) begin
            if (tbl[k].q !== (tbl[k].sel ? tbl[k].d1 : tbl[k].d0))
                $display("FAIL table_v%0d: q column inconsistent", k);
        end

        run("good", 0, NV + 5, 1'b1, 16'd0, 16'hFFFF, 0, 0);
`ifdef MUX_DFF_BIST_STOP_ON_FAIL_EN
        run("stuck0", 1, 11, 1'b0, 16'd1, 16'd6, 0, 0);
        run("stuck1", 2, 5, 1'b0, 16'd1, 16'd0, 0, 0);
`else
        run("stuck0", 1, NV + 5, 1'b0, 16'd9, 16'd6, 0, 0);
        run("stuck1", 2, NV + 5, 1'b0, 16'd8, 16'd0, 0, 0);
`endif

        // Abort while vector 5 is on the pins.
        begin
            int dc0;
            fault = 0;
            dc0 = done_cnt;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            repeat (6) @(negedge clk);
            check_stim(5);
            rst_n = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_pass", pass, 0);
            check("abort_err_count", err_count, 0);
            check("abort_fail_vec", fail_vec, 16'hFFFF);
            check("abort_stim", {dut_rst, dut_d0, dut_d1, dut_sel}, 4'b1000);
            repeat (30) @(negedge clk);
            check("abort_no_done", done_cnt - dc0, 0);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        run("replay", 0, NV + 5, 1'b1, 16'd0, 16'hFFFF, 0, 0);

        // Spurious starts in RUN (negedge 8) and coincident with FIN (negedge 20).
        run("spur_good", 0, NV + 5, 1'b1, 16'd0, 16'hFFFF, 8, NV + 4);
`ifndef MUX_DFF_BIST_STOP_ON_FAIL_EN
        run("spur_stuck0", 1, NV + 5, 1'b0, 16'd9, 16'd6, 8, NV + 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
